// File: rtl/array_alloc_arbiter.sv
// array_alloc_arbiter
// Shared heap-array allocator and free controller for several requesters.
// Requests are granted round-robin, one operation at a time. A freed array
// index goes onto a LIFO stack and is handed out again before any fresh
// index. Each successful allocation zeroes the array's size entry and then
// its heap area, one heap word per cycle.
//
// Optional build macro: ALLOC_DOUBLE_FREE_CHECK_EN
//   When defined, a live bitmap tracks allocated arrays. Freeing an index
//   that is not live fails with rsp_error and changes nothing.
//   When undefined, a double free is accepted. Only the range check and the
//   stack-full check apply.
//
// Ports
//   clock       system clock, all logic on posedge
//   reset       synchronous active-high reset, forces every output to 0
//   req_valid   per-requester request, held until req_ready
//   req_free    per-requester op select (1 = free, 0 = alloc)
//   req_array   per-requester array index to free (MemoryElementWidth slices)
//   req_ready   one-hot accept pulse
//   rsp_valid   one-hot completion pulse to the granted requester
//   rsp_array   allocated index, or the echoed index of a free
//   rsp_error   operation failed, qualified by rsp_valid
//   heap_we     heap write strobe during the clear sequence
//   heap_addr   heap write address (index*NArea + k)
//   heap_wdata  heap write data, always 0
//   size_we     arraySizes write strobe, on the first clear cycle only
//   size_addr   arraySizes index
//   in_use      arrays currently allocated (allocs - freed stack depth)
module array_alloc_arbiter #(
    parameter int MemoryElementWidth = 12,
    parameter int NArea              = 7,
    parameter int NArrays            = 4,
    parameter int NReq               = 2
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NReq-1:0]                    req_valid,
    input  logic [NReq-1:0]                    req_free,
    input  logic [NReq*MemoryElementWidth-1:0] req_array,
    output logic [NReq-1:0]                    req_ready,
    output logic [NReq-1:0]                    rsp_valid,
    output logic [MemoryElementWidth-1:0]      rsp_array,
    output logic                               rsp_error,
    output logic                               heap_we,
    output logic [MemoryElementWidth-1:0]      heap_addr,
    output logic [MemoryElementWidth-1:0]      heap_wdata,
    output logic                               size_we,
    output logic [MemoryElementWidth-1:0]      size_addr,
    output logic [MemoryElementWidth-1:0]      in_use
);

    localparam int W  = MemoryElementWidth;
    localparam int CW = $clog2(NArrays + 1);
    localparam int IW = (NArrays > 1) ? $clog2(NArrays) : 1;
    localparam int RW = (NReq > 1) ? $clog2(NReq) : 1;

    typedef enum logic [1:0] {IDLE, CLEAR, EXEC, RESP} state_t;

    state_t         state, next_state;
    logic [RW-1:0]  rr, gnt, grant_idx, cand;
    logic           grant_found;
    logic [W-1:0]   grant_array;
    logic           op_free, err, exec_err, can_alloc, clear_last;
    logic [W-1:0]   op_array, index, result, k;
    logic [CW-1:0]  allocs, freed_top;
    logic [W-1:0]   freed [NArrays];
    logic [IW-1:0]  push_slot, pop_slot;
`ifdef ALLOC_DOUBLE_FREE_CHECK_EN
    logic [NArrays-1:0] live;
`endif

    // Round-robin search. The search starts one past the last grant, so the
    // most recently served requester has the lowest priority.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 1; i <= NReq; i++) begin
            cand = RW'((int'(rr) + i) % NReq);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign grant_array = req_array[int'(grant_idx)*W +: W];
    assign push_slot   = freed_top[IW-1:0];
    assign pop_slot    = IW'(freed_top - CW'(1));
    assign can_alloc   = (freed_top != '0) || (allocs < CW'(NArrays));
    assign clear_last  = (k == W'(NArea - 1));

    // A free fails when it is out of range or the stack is full. With the
    // double-free check enabled, it also fails when the index is not live.
    always_comb begin
        exec_err = (op_array >= W'(NArrays)) || (freed_top == CW'(NArrays));
`ifdef ALLOC_DOUBLE_FREE_CHECK_EN
        if (!exec_err && !live[op_array[IW-1:0]]) begin
            exec_err = 1'b1;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and outputs. While reset is high, every output is
    // forced to 0, so an aborted clear produces no stray write or response.
    always_comb begin
        next_state = state;
        req_ready  = '0;
        rsp_valid  = '0;
        rsp_array  = '0;
        rsp_error  = 1'b0;
        heap_we    = 1'b0;
        heap_addr  = '0;
        heap_wdata = '0;
        size_we    = 1'b0;
        size_addr  = '0;
        in_use     = W'(allocs) - W'(freed_top);
        case (state)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    if (!req_free[grant_idx] && can_alloc) begin
                        next_state = CLEAR;
                    end else begin
                        next_state = EXEC;
                    end
                end
            end
            CLEAR: begin
                heap_we   = 1'b1;
                heap_addr = index * W'(NArea) + k;
                if (k == '0) begin
                    size_we   = 1'b1;
                    size_addr = index;
                end
                if (clear_last) begin
                    next_state = RESP;
                end
            end
            EXEC: begin
                next_state = RESP;
            end
            RESP: begin
                rsp_valid[gnt] = 1'b1;
                rsp_array      = result;
                rsp_error      = err;
                next_state     = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (reset) begin
            next_state = IDLE;
            req_ready  = '0;
            rsp_valid  = '0;
            rsp_array  = '0;
            rsp_error  = 1'b0;
            heap_we    = 1'b0;
            heap_addr  = '0;
            size_we    = 1'b0;
            size_addr  = '0;
            in_use     = '0;
        end
    end

    // Datapath. An alloc commits its index in the accept cycle, so in_use
    // counts the array immediately. A free commits only in EXEC, after its
    // checks have been evaluated.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr        <= '0;
            gnt       <= '0;
            op_free   <= 1'b0;
            op_array  <= '0;
            index     <= '0;
            result    <= '0;
            err       <= 1'b0;
            k         <= '0;
            allocs    <= '0;
            freed_top <= '0;
`ifdef ALLOC_DOUBLE_FREE_CHECK_EN
            live      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        rr       <= grant_idx;
                        gnt      <= grant_idx;
                        op_free  <= req_free[grant_idx];
                        op_array <= grant_array;
                        k        <= '0;
                        err      <= 1'b0;
                        if (req_free[grant_idx]) begin
                            result <= grant_array;
                        end else if (freed_top != '0) begin
                            freed_top <= freed_top - CW'(1);
                            index     <= freed[pop_slot];
                            result    <= freed[pop_slot];
`ifdef ALLOC_DOUBLE_FREE_CHECK_EN
                            live[freed[pop_slot][IW-1:0]] <= 1'b1;
`endif
                        end else if (allocs < CW'(NArrays)) begin
                            allocs <= allocs + CW'(1);
                            index  <= W'(allocs);
                            result <= W'(allocs);
`ifdef ALLOC_DOUBLE_FREE_CHECK_EN
                            live[allocs[IW-1:0]] <= 1'b1;
`endif
                        end else begin
                            result <= '0;
                            err    <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    k <= k + W'(1);
                end
                EXEC: begin
                    if (op_free) begin
                        err <= exec_err;
                        if (!exec_err) begin
                            freed[push_slot] <= op_array;
                            freed_top        <= freed_top + CW'(1);
`ifdef ALLOC_DOUBLE_FREE_CHECK_EN
                            live[op_array[IW-1:0]] <= 1'b0;
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_array_alloc_arbiter.sv
// tb_array_alloc_arbiter
// Directed bench for array_alloc_arbiter with its default parameters
// (12-bit elements, NArea=7, NArrays=4, NReq=2). Expected responses are queued
// when a request is driven and compared when rsp_valid appears. The
// double-free scenario follows ALLOC_DOUBLE_FREE_CHECK_EN in the same way as
// the design.
module tb_array_alloc_arbiter;

    localparam int W     = 12;
    localparam int NArea = 7;

    typedef struct {
        int         req;
        logic [W-1:0] arr;
        logic       err;
        int         lat;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset;
    logic [1:0]   req_valid;
    logic [1:0]   req_free;
    logic [2*W-1:0] req_array;
    logic [1:0]   req_ready;
    logic [1:0]   rsp_valid;
    logic [W-1:0] rsp_array;
    logic         rsp_error;
    logic         heap_we;
    logic [W-1:0] heap_addr;
    logic [W-1:0] heap_wdata;
    logic         size_we;
    logic [W-1:0] size_addr;
    logic [W-1:0] in_use;

    exp_t sb[$];
    int   assertCount = 0;
    int   failCount   = 0;

    array_alloc_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_free   (req_free),
        .req_array  (req_array),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_array  (rsp_array),
        .rsp_error  (rsp_error),
        .heap_we    (heap_we),
        .heap_addr  (heap_addr),
        .heap_wdata (heap_wdata),
        .size_we    (size_we),
        .size_addr  (size_addr),
        .in_use     (in_use)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int req, input logic free, input logic [W-1:0] arr);
        req_valid[req]          = 1'b1;
        req_free[req]           = free;
        req_array[req*W +: W]   = arr;
    endtask

    task automatic resetDut();
        reset     = 1'b1;
        req_valid = 2'b01;
        req_free  = 2'b00;
        req_array = '0;
        #1;
        checkOutput("ready_in_reset", 32'(req_ready), 32'(0));
        repeat (2) @(posedge clock);
        #1;
        req_valid = 2'b00;
        reset     = 1'b0;
        #1;
    endtask

    // One complete operation. The request is driven in an IDLE cycle T. The
    // heap writes are then checked against the expected index, and the
    // response against the scoreboard entry.
    task automatic runOp(input int req, input logic free, input logic [W-1:0] arr,
                         input logic [W-1:0] expArr, input logic expErr,
                         input int expLat, input int expHeap);
        int   cyc;
        int   heapCount;
        bit   got;
        exp_t e;
        @(posedge clock);
        #1;
        applyStimulus(req, free, arr);
        #1;
        checkOutput("req_ready", 32'(req_ready), 32'(1 << req));
        sb.push_back('{req, expArr, expErr, expLat});
        @(posedge clock);
        #1;
        req_valid = 2'b00;
        cyc       = 1;
        heapCount = 0;
        got       = 1'b0;
        while (!got && cyc < 20) begin
            if (heap_we) begin
                checkOutput("heap_addr", 32'(heap_addr), 32'(expArr) * NArea + 32'(heapCount));
                checkOutput("heap_wdata", 32'(heap_wdata), 32'(0));
                heapCount++;
            end
            if (size_we) begin
                checkOutput("size_we_cycle", 32'(cyc), 32'(1));
                checkOutput("size_addr", 32'(size_addr), 32'(expArr));
            end
            if (rsp_valid != 2'b00) begin
                e = sb.pop_front();
                checkOutput("rsp_valid", 32'(rsp_valid), 32'(1 << e.req));
                checkOutput("rsp_array", 32'(rsp_array), 32'(e.arr));
                checkOutput("rsp_error", 32'(rsp_error), 32'(e.err));
                checkOutput("rsp_latency", 32'(cyc), 32'(e.lat));
                got = 1'b1;
            end else begin
                @(posedge clock);
                #1;
                cyc++;
            end
        end
        checkOutput("rsp_seen", 32'(got), 32'(1));
        checkOutput("heap_write_count", 32'(heapCount), 32'(expHeap));
    endtask

    initial begin
        int   cyc;
        int   responses;
        int   acceptCyc;
        bit   drop0;
        bit   sawRsp;
        exp_t e;

        $display("[TB] start");
        resetDut();
        checkOutput("reset_in_use", 32'(in_use), 32'(0));
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'(0));
        checkOutput("reset_heap_we", 32'(heap_we), 32'(0));
        checkOutput("reset_size_we", 32'(size_we), 32'(0));

        // First alloc clears heap 0..6, and the response arrives at T+8.
        runOp(0, 1'b0, '0, 12'd0, 1'b0, 8, NArea);
        checkOutput("in_use_1", 32'(in_use), 32'(1));

        // Fill the table, then one alloc too many.
        runOp(0, 1'b0, '0, 12'd1, 1'b0, 8, NArea);
        runOp(1, 1'b0, '0, 12'd2, 1'b0, 8, NArea);
        runOp(0, 1'b0, '0, 12'd3, 1'b0, 8, NArea);
        checkOutput("in_use_4", 32'(in_use), 32'(4));
        runOp(1, 1'b0, '0, 12'd0, 1'b1, 2, 0);
        checkOutput("in_use_full", 32'(in_use), 32'(4));

        // Free 2, then reuse it LIFO-style, which clears heap 14..20.
        runOp(0, 1'b1, 12'd2, 12'd2, 1'b0, 2, 0);
        checkOutput("in_use_after_free", 32'(in_use), 32'(3));
        runOp(1, 1'b0, '0, 12'd2, 1'b0, 8, NArea);
        checkOutput("in_use_reuse", 32'(in_use), 32'(4));

        // Out-of-range free.
        runOp(0, 1'b1, 12'd5, 12'd5, 1'b1, 2, 0);
        checkOutput("in_use_bad_free", 32'(in_use), 32'(4));

        // Both requesters alloc together from reset. req1 wins first.
        resetDut();
        @(posedge clock);
        #1;
        req_free  = 2'b00;
        req_valid = 2'b11;
        #1;
        checkOutput("dual_first_grant", 32'(req_ready), 32'(2'b10));
        sb.push_back('{1, 12'd0, 1'b0, 8});
        sb.push_back('{0, 12'd1, 1'b0, 8});
        responses = 0;
        cyc       = 0;
        acceptCyc = 0;
        drop0     = 1'b0;
        while (responses < 2 && cyc < 60) begin
            @(posedge clock);
            #1;
            cyc++;
            if (cyc == 1) req_valid[1] = 1'b0;
            if (drop0) begin
                req_valid[0] = 1'b0;
                drop0        = 1'b0;
            end
            #1;
            checkOutput("ready_onehot", 32'($countones(req_ready) <= 1), 32'(1));
            if (req_ready[0]) begin
                acceptCyc = cyc;
                drop0     = 1'b1;
            end
            if (rsp_valid != 2'b00) begin
                e = sb.pop_front();
                checkOutput("dual_rsp_valid", 32'(rsp_valid), 32'(1 << e.req));
                checkOutput("dual_rsp_array", 32'(rsp_array), 32'(e.arr));
                checkOutput("dual_rsp_error", 32'(rsp_error), 32'(e.err));
                checkOutput("dual_rsp_latency", 32'(cyc - acceptCyc), 32'(e.lat));
                responses++;
            end
        end
        checkOutput("dual_responses", 32'(responses), 32'(2));
        checkOutput("dual_in_use", 32'(in_use), 32'(2));

        // Reset in the middle of a clear, at k=3.
        resetDut();
        @(posedge clock);
        #1;
        applyStimulus(0, 1'b0, '0);
        #1;
        checkOutput("midclr_ready", 32'(req_ready), 32'(2'b01));
        @(posedge clock);
        #1;
        req_valid = 2'b00;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("midclr_k3_we", 32'(heap_we), 32'(1));
        checkOutput("midclr_k3_addr", 32'(heap_addr), 32'(3));
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("midclr_heap_we", 32'(heap_we), 32'(0));
        checkOutput("midclr_in_use", 32'(in_use), 32'(0));
        sawRsp = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid != 2'b00) sawRsp = 1'b1;
            @(posedge clock);
            #1;
        end
        checkOutput("midclr_no_rsp", 32'(sawRsp), 32'(0));
        runOp(0, 1'b0, '0, 12'd0, 1'b0, 8, NArea);

        // Double free of index 0.
        resetDut();
        runOp(0, 1'b0, '0, 12'd0, 1'b0, 8, NArea);
        runOp(1, 1'b1, 12'd0, 12'd0, 1'b0, 2, 0);
`ifdef ALLOC_DOUBLE_FREE_CHECK_EN
        runOp(0, 1'b1, 12'd0, 12'd0, 1'b1, 2, 0);
        checkOutput("double_free_in_use", 32'(in_use), 32'(0));
`else
        runOp(0, 1'b1, 12'd0, 12'd0, 1'b0, 2, 0);
`endif

        checkOutput("scoreboard_empty", 32'(sb.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/array_alloc_arbiter.md
Name: array_alloc_arbiter

Overview:
- Shared heap-array allocator/free controller for multi-requester program engines.
- Arbitrates alloc/free requests round-robin.
- Reuses freed arrays via a LIFO stack, otherwise takes the next fresh index.
- On allocation, sequences zeroing of the array size entry and its heap area, one write per cycle.

Parameters:
- MemoryElementWidth, 12, width of array indices, heap addresses and data.
- NArea, 7, heap words per array area.
- NArrays, 4, maximum number of arrays; also the free-stack depth.
- NReq, 2, number of requesters.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NReq  request pending, one bit per requester; held until req_ready.
- req_free  in  NReq  per-requester op: 1 = free, 0 = alloc.
- req_array  in  NReq*MemoryElementWidth  array index to free, slice per requester.
- req_ready  out  NReq  one-hot, one-cycle accept pulse.
- rsp_valid  out  NReq  one-hot, one-cycle completion pulse to the granted requester.
- rsp_array  out  MemoryElementWidth  allocated index; echoes the index on free.
- rsp_error  out  1  operation failed; qualified by rsp_valid.
- heap_we  out  1  heap write strobe.
- heap_addr  out  MemoryElementWidth  heap write address.
- heap_wdata  out  MemoryElementWidth  heap write data; constant 0.
- size_we  out  1  arraySizes write strobe (writes 0).
- size_addr  out  MemoryElementWidth  arraySizes index.
- in_use  out  MemoryElementWidth  arrays currently allocated = allocs - freedTop.

Behaviour:
- Reset (synchronous, active-high; applies mid-operation too):
  - state=IDLE; allocs=0; freedTop=0; rr pointer=0.
  - All outputs 0. An in-flight clear is aborted and no rsp is issued.
- IDLE:
  - If any req_valid, grant the first set bit searching from rr+1, wrapping modulo NReq.
  - req_ready[g]=1 combinationally in that cycle.
  - Latch op and array; rr=g.
  - Next state is EXEC for a free, or for an alloc with no room; otherwise CLEAR.
- Alloc index selection (in the accept cycle):
  - If freedTop>0: freedTop--, index=freed[freedTop].
  - Else if allocs<NArrays: index=allocs, allocs++.
  - Else: error; go to EXEC with no state change.
- CLEAR (NArea cycles, k=0..NArea-1):
  - heap_we=1, heap_addr=index*NArea+k, heap_wdata=0.
  - size_we=1 and size_addr=index on k=0 only.
  - After k=NArea-1, go to RESP.
- EXEC (free, 1 cycle):
  - Error if array>=NArrays or freedTop==NArrays.
  - Otherwise freed[freedTop]=array, freedTop++.
  - Go to RESP.
- RESP (1 cycle):
  - rsp_valid[g]=1; rsp_array and rsp_error valid this cycle only.
  - Return to IDLE. A new grant is possible the next cycle, not in RESP.
- Latency from the accept cycle T:
  - Successful alloc: rsp at T+NArea+1.
  - Free, or failed alloc: rsp at T+2.
- Simultaneous requests: exactly one grant per IDLE cycle; a losing request stays pending with req_ready=0.
- Arithmetic:
  - heap_addr is computed at MemoryElementWidth; truncation is the integrator's responsibility (NArrays*NArea must fit).
  - in_use never negative, given the checks above.
- Only one op is outstanding at a time; no pipelining across requesters.

Optional Feature:
- Macro: ALLOC_DOUBLE_FREE_CHECK_EN.
- Defined:
  - Keep an NArrays-bit live bitmap: set on successful alloc, cleared on successful free.
  - Freeing an index whose bit is 0 raises rsp_error=1; no push, no state change.
- Undefined:
  - No bitmap.
  - A double free is accepted and pushed, subject only to the range and stack-full checks.

Test Plan:
- After reset, req0 alloc:
  - req_ready[0] at T; heap_we at addrs 0..6 in T+1..T+7; size_we addr 0 at T+1.
  - rsp_valid[0] at T+8 with rsp_array=0, error=0; in_use=1.
- Four allocs return 0,1,2,3; a fifth returns rsp_error=1 at T+2 with no heap_we; in_use=4.
- Free 2, then alloc:
  - The free completes at T+2 with error=0.
  - The alloc returns rsp_array=2 (LIFO reuse) and clears heap 14..20.
- Both requesters hold alloc from reset:
  - req1 is granted first (rr=0 → search starts at 1), then req0.
  - Responses return indices 0 then 1; req_ready never two-hot.
- Reset asserted at clear cycle k=3:
  - Next cycle heap_we=0; no rsp_valid; allocs=0.
  - A following alloc returns index 0.
- Free array 5 (>=NArrays) gives error=1.
- With ALLOC_DOUBLE_FREE_CHECK_EN: alloc 0, free 0, free 0 → second free error=1, in_use=0.
